fifo_param: RTL and testbench

Parametrised synchronous FIFO; successor to the fixed 8-bit single-mode FIFO. Adds configurable data width and depth, occupancy count, programmable almost-full/almost-empty thresholds, and a selectable first-word-fall-through (FWFT) read mode. Sits between a producer and a consumer in one clock domain. Keeps the single-cycle `full_err`/`empty_err` overflow/underflow pulses.

---
 rtl/fifo_param.sv | 105 ++++++++++
 tb/tb_fifo_param.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable almost-full/almost-empty
// thresholds and a selectable registered or first-word-fall-through read port.
module fifo_param #(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned AF_LEVEL = DEPTH - 2,
   parameter int unsigned AE_LEVEL = 2,
   parameter bit          FWFT     = 1'b0,
   localparam int unsigned AW      = $clog2(DEPTH),
   localparam int unsigned CW      = AW + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr,
   input  logic              rd,
   input  logic [DATA_W-1:0] datain,
   output logic [DATA_W-1:0] dataout,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic [CW-1:0]     count,
   output logic              full_err,
   output logic              empty_err
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [CW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              full_err_q, full_err_d;
   logic              empty_err_q, empty_err_d;
   logic              rd_ok, wr_ok;
   logic [AW-1:0]     rd_idx;

   assign full         = (count_q == CW'(DEPTH));
   assign empty        = (count_q == '0);
   assign almost_full  = (count_q >= CW'(AF_LEVEL));
   assign almost_empty = (count_q <= CW'(AE_LEVEL));
   assign count        = count_q;
   assign full_err     = full_err_q;
   assign empty_err    = empty_err_q;
   assign rd_idx       = rd_ptr_q[AW-1:0];

   always_comb begin
      rd_ok = rd && !empty;
      // A write to a full FIFO is only accepted when a read frees a slot on the same edge.
      wr_ok = wr && (!full || rd_ok);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_ok) wr_ptr_d = wr_ptr_q + CW'(1);
      if (rd_ok) rd_ptr_d = rd_ptr_q + CW'(1);
      if (wr_ok && !rd_ok) begin
         count_d = count_q + CW'(1);
      end else if (rd_ok && !wr_ok) begin
         count_d = count_q - CW'(1);
      end
      full_err_d  = wr && full && !rd_ok;
      empty_err_d = rd && empty;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         full_err_q  <= 1'b0;
         empty_err_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         full_err_q  <= full_err_d;
         empty_err_q <= empty_err_d;
      end
   end

   // Storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (wr_ok) mem_q[wr_ptr_q[AW-1:0]] <= datain;
   end

   if (FWFT) begin : g_fwft
      assign dataout = mem_q[rd_idx];
   end else begin : g_reg
      logic [DATA_W-1:0] dout_q, dout_d;

      always_comb begin
         dout_d = dout_q;
         if (rd_ok) dout_d = mem_q[rd_idx];
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            dout_q <= '0;
         end else begin
            dout_q <= dout_d;
         end
      end

      assign dataout = dout_q;
   end

endmodule

// File: tb/tb_fifo_param.sv
// Directed bench for fifo_param: a queue scoreboard and occupancy model drive expectations
// for the registered-read instance; a second instance exercises first-word-fall-through.
module tb_fifo_param;

   logic       clk = 1'b0;
   logic       rst;
   logic       wr, rd;
   logic [7:0] din, dout;
   logic       full, empty, af, ae, ferr, eerr;
   logic [4:0] count;

   logic       wr1, rd1;
   logic [7:0] din1, dout1;
   logic       full1, empty1, af1, ae1, ferr1, eerr1;
   logic [4:0] count1;

   int         passed = 0;
   int         total  = 0;
   logic [7:0] q[$];
   int         mcount = 0;
   logic [7:0] mdout  = 8'h00;

   always #5 clk = ~clk;

   fifo_param #(.DATA_W(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1'b0)) u_reg (
      .clk(clk), .rst(rst), .wr(wr), .rd(rd), .datain(din), .dataout(dout),
      .full(full), .empty(empty), .almost_full(af), .almost_empty(ae), .count(count),
      .full_err(ferr), .empty_err(eerr)
   );

   fifo_param #(.DATA_W(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1'b1)) u_fwft (
      .clk(clk), .rst(rst), .wr(wr1), .rd(rd1), .datain(din1), .dataout(dout1),
      .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1), .count(count1),
      .full_err(ferr1), .empty_err(eerr1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input logic exp_ferr, input logic exp_eerr);
      chk("count", 32'(count), 32'(mcount));
      chk("full", 32'(full), 32'(mcount == 16));
      chk("empty", 32'(empty), 32'(mcount == 0));
      chk("almost_full", 32'(af), 32'(mcount >= 14));
      chk("almost_empty", 32'(ae), 32'(mcount <= 2));
      chk("full_err", 32'(ferr), 32'(exp_ferr));
      chk("empty_err", 32'(eerr), 32'(exp_eerr));
      chk("dataout", 32'(dout), 32'(mdout));
   endtask

   // One clock edge on the registered-read instance, with the model advanced alongside.
   task automatic step(input logic w, input logic r, input logic [7:0] d);
      logic rok, wok, xferr, xeerr;
      rok   = r && (mcount != 0);
      wok   = w && ((mcount != 16) || rok);
      xferr = w && (mcount == 16) && !rok;
      xeerr = r && (mcount == 0);
      wr = w;
      rd = r;
      din = d;
      tick;
      if (rok) mdout = q.pop_front();
      if (wok) q.push_back(d);
      mcount = mcount + int'(wok) - int'(rok);
      wr = 1'b0;
      rd = 1'b0;
      check_all(xferr, xeerr);
   endtask

   initial begin
      rst = 1'b1;
      wr = 1'b0; rd = 1'b0; din = 8'h00;
      wr1 = 1'b0; rd1 = 1'b0; din1 = 8'h00;
      #12;
      rst = 1'b0;
      check_all(1'b0, 1'b0);

      // Asynchronous reset with five words held and a non-zero output register.
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'(8'h30 + i));
      step(1'b0, 1'b1, 8'h00);
      chk("pre_reset_count", 32'(count), 32'd5);
      #3;
      rst = 1'b1;
      #1;
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_dataout", 32'(dout), 32'd0);
      chk("rst_full_err", 32'(ferr), 32'd0);
      chk("rst_empty_err", 32'(eerr), 32'd0);
      mcount = 0;
      mdout = 8'h00;
      q.delete();
      @(negedge clk);
      rst = 1'b0;

      // Overflow: 18 writes, the last two dropped.
      for (int i = 0; i < 18; i++) step(1'b1, 1'b0, 8'(i));
      // Underflow: 18 reads, the last two rejected.
      for (int i = 0; i < 18; i++) step(1'b0, 1'b1, 8'h00);
      chk("underflow_hold", 32'(dout), 32'h0f);

      // Simultaneous write and read while empty.
      step(1'b1, 1'b1, 8'h77);
      chk("wr_rd_empty_count", 32'(count), 32'd1);

      // Simultaneous write and read while full.
      for (int i = 0; i < 15; i++) step(1'b1, 1'b0, 8'(8'h80 + i));
      step(1'b1, 1'b1, 8'hAA);
      chk("wr_rd_full_head", 32'(dout), 32'h77);
      chk("wr_rd_full_count", 32'(count), 32'd16);
      for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'h00);
      chk("last_is_aa", 32'(dout), 32'hAA);

      // Streaming across several pointer wraps at occupancy 3.
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'hC0 + i));
      for (int i = 3; i < 43; i++) step(1'b1, 1'b1, 8'(8'hC0 + i));
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h00);
      chk("stream_tail", 32'(dout), 32'hEA);

      // First-word-fall-through instance.
      wr1 = 1'b1; din1 = 8'h5A;
      tick;
      wr1 = 1'b0;
      chk("fwft_not_empty", 32'(empty1), 32'd0);
      chk("fwft_head", 32'(dout1), 32'h5A);
      wr1 = 1'b1; din1 = 8'h5B;
      tick;
      wr1 = 1'b0;
      chk("fwft_head_held", 32'(dout1), 32'h5A);
      chk("fwft_count2", 32'(count1), 32'd2);
      rd1 = 1'b1;
      tick;
      rd1 = 1'b0;
      chk("fwft_advance", 32'(dout1), 32'h5B);
      chk("fwft_count1", 32'(count1), 32'd1);
      rd1 = 1'b1;
      tick;
      chk("fwft_empty", 32'(empty1), 32'd1);
      tick;
      rd1 = 1'b0;
      chk("fwft_empty_err", 32'(eerr1), 32'd1);
      chk("fwft_full_err", 32'(ferr1), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
